// File: rtl/core_pkg.sv
// Shared definitions for the integer register file slice.
//
// Holds the default geometry (data width, register count, address width,
// producer tag width), the enable-level constants used by the read ports,
// the all-zero data word written by the post-reset fill, and the fill
// sequencer state type.
package core_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int AW_DEF    = $clog2(NREG_DEF);
    localparam int TAG_W_DEF = 4;

    localparam logic EN_ON  = 1'b1;
    localparam logic EN_OFF = 1'b0;

    localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;

    // INIT: zero-filling registers 1..NREG-1 after reset.
    // RUN : normal operation until the next reset.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } fill_state_t;

endpackage

// File: rtl/regfile_rdport.sv
// One combinational read port of regfile_sb.
//
// Ports:
//   en     - register file is in RUN; when low the port outputs zero
//   re     - read enable for this port
//   raddr  - register to read
//   regs   - view of the whole data array
//   busy   - registered busy bits of the scoreboard
//   tags   - registered producer tags of the scoreboard
//   we, waddr, wdata, wtag - the commit port, used for the same-cycle
//            data bypass and the same-cycle busy clear
//   rdata  - read data (0 for register 0, disabled port or not ready)
//   rbusy  - register has an outstanding producer
//   rtag   - producer tag of the register
module regfile_rdport
    import core_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int AW    = $clog2(NREG)
) (
    input  logic                        en,
    input  logic                        re,
    input  logic [AW-1:0]               raddr,
    input  logic [NREG-1:0][XLEN-1:0]   regs,
    input  logic [NREG-1:0]             busy,
    input  logic [NREG-1:0][TAG_W-1:0]  tags,
    input  logic                        we,
    input  logic [AW-1:0]               waddr,
    input  logic [XLEN-1:0]             wdata,
    input  logic [TAG_W-1:0]            wtag,
    output logic [XLEN-1:0]             rdata,
    output logic                        rbusy,
    output logic [TAG_W-1:0]            rtag
);

    logic hit;
    logic wr_match;

    assign hit      = (en == EN_ON) && (re == EN_ON) && (raddr != '0);
    assign wr_match = (we == EN_ON) && (waddr == raddr);

    // NOTE: every output gets a default before the conditional logic so that
    // no path leaves a value unassigned, which would infer a latch.
    always_comb begin
        rdata = '0;
        rbusy = 1'b0;
        rtag  = '0;
        if (hit) begin
            rdata = wr_match ? wdata : regs[raddr];
            rtag  = tags[raddr];
            // A commit whose tag matches the outstanding producer retires it
            // at the coming edge; show that retirement already this cycle.
            rbusy = busy[raddr] && !(wr_match && (tags[raddr] == wtag));
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with rename scoreboard for the out-of-order issue
// stage.
//
// After reset a sequencer writes zero into registers 1..NREG-1, one per
// cycle, then raises ready. Register 0 is hard-wired to zero and is never
// written. The scoreboard keeps a busy bit and producer tag per register:
// issue claims a destination, commit retires it when the tags match, and
// flush clears every busy bit.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - asynchronous active-low reset
//   ready      - high once the zero-fill is complete
//   flush      - clear all busy bits (drops a same-cycle claim)
//   re         - per-port read enable           [NRD]
//   raddr      - packed read addresses           [NRD*AW], port i at [i*AW +: AW]
//   rdata      - packed read data                [NRD*XLEN]
//   rbusy      - per-port busy flag              [NRD]
//   rtag       - packed producer tags            [NRD*TAG_W]
//   iss_valid, iss_rd, iss_tag - destination claim from issue
//   we, waddr, wdata, wtag     - architectural write from commit
module regfile_sb
    import core_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREG  = NREG_DEF,
    parameter  int NRD   = 2,
    parameter  int TAG_W = TAG_W_DEF,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  flush,
    input  logic [NRD-1:0]        re,
    input  logic [NRD*AW-1:0]     raddr,
    output logic [NRD*XLEN-1:0]   rdata,
    output logic [NRD-1:0]        rbusy,
    output logic [NRD*TAG_W-1:0]  rtag,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    input  logic [TAG_W-1:0]      iss_tag,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [XLEN-1:0]       wdata,
    input  logic [TAG_W-1:0]      wtag
);

    localparam logic [AW-1:0] LAST_REG  = AW'(NREG - 1);
    localparam logic [AW-1:0] FIRST_REG = AW'(1);

    fill_state_t               state;
    fill_state_t               state_next;
    logic [AW-1:0]             cnt;
    logic [AW-1:0]             cnt_next;

    logic [NREG-1:0][XLEN-1:0]  regs;
    logic [NREG-1:0]            busy;
    logic [NREG-1:0][TAG_W-1:0] tags;

    logic                      run;
    logic                      commit;
    logic                      commit_clear;
    logic                      claim;
    logic                      arr_we;
    logic [AW-1:0]             arr_addr;
    logic [XLEN-1:0]           arr_data;

    assign run   = (state == ST_RUN);
    // state is a flop, so ready is a registered output.
    assign ready = run;

    assign commit       = run && we && (waddr != '0);
    assign commit_clear = commit && busy[waddr] && (tags[waddr] == wtag);
    assign claim        = run && iss_valid && (iss_rd != '0);

    // ------------------------------------------------------------------
    // Fill sequencer
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so
    // every flop samples the values from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
            cnt   <= FIRST_REG;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        arr_we     = 1'b0;
        arr_addr   = waddr;
        arr_data   = wdata;
        case (state)
            ST_INIT: begin
                // The fill owns the write port; commits are ignored here.
                arr_we   = 1'b1;
                arr_addr = cnt;
                arr_data = XLEN'(ZERO_WORD);
                if (cnt == LAST_REG) begin
                    state_next = ST_RUN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                arr_we = commit;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Data array
    // ------------------------------------------------------------------
    // NOTE: the data array deliberately has no reset; the fill sequencer
    // zeroes it instead, which keeps it mappable to plain storage.
    always_ff @(posedge clk) begin
        if (arr_we) begin
            regs[arr_addr] <= arr_data;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    // Within a cycle the claim is written after the commit clear, so a
    // claim and a matching commit to the same register leave it busy with
    // the new tag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            tags <= '0;
        end else if (run) begin
            if (flush) begin
                busy <= '0;
            end else begin
                if (commit_clear) begin
                    busy[waddr] <= 1'b0;
                end
                if (claim) begin
                    busy[iss_rd] <= 1'b1;
                    tags[iss_rd] <= iss_tag;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_rdport #(
            .XLEN  (XLEN),
            .NREG  (NREG),
            .TAG_W (TAG_W),
            .AW    (AW)
        ) u_rdport (
            .en    (run),
            .re    (re[i]),
            .raddr (raddr[i*AW +: AW]),
            .regs  (regs),
            .busy  (busy),
            .tags  (tags),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .wtag  (wtag),
            .rdata (rdata[i*XLEN +: XLEN]),
            .rbusy (rbusy[i]),
            .rtag  (rtag[i*TAG_W +: TAG_W])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb with the default geometry
// (XLEN=32, NREG=32, NRD=2, TAG_W=4). Inputs change on the falling clock
// edge; combinational outputs are checked shortly afterwards and state
// updates are observed one falling edge later.
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NRD   = 2;
    localparam int TAG_W = 4;
    localparam int AW    = 5;

    logic                  clk;
    logic                  rst;
    logic                  ready;
    logic                  flush;
    logic [NRD-1:0]        re;
    logic [NRD*AW-1:0]     raddr;
    logic [NRD*XLEN-1:0]   rdata;
    logic [NRD-1:0]        rbusy;
    logic [NRD*TAG_W-1:0]  rtag;
    logic                  iss_valid;
    logic [AW-1:0]         iss_rd;
    logic [TAG_W-1:0]      iss_tag;
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [XLEN-1:0]       wdata;
    logic [TAG_W-1:0]      wtag;

    int checks = 0;
    int errors = 0;
    int cycles;

    regfile_sb #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .NRD   (NRD),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .flush     (flush),
        .re        (re),
        .raddr     (raddr),
        .rdata     (rdata),
        .rbusy     (rbusy),
        .rtag      (rtag),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .iss_tag   (iss_tag),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .wtag      (wtag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rd(input int p, input int a, input logic en);
        raddr[p*AW +: AW] = AW'(a);
        re[p]             = en;
    endtask

    function automatic logic [XLEN-1:0] rd_data(input int p);
        return rdata[p*XLEN +: XLEN];
    endfunction

    function automatic logic [TAG_W-1:0] rd_tag(input int p);
        return rtag[p*TAG_W +: TAG_W];
    endfunction

    task automatic wait_ready();
        cycles = 0;
        while (ready !== 1'b1 && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; re = '0; raddr = '0;
        iss_valid = 1'b0; iss_rd = '0; iss_tag = '0;
        we = 1'b0; waddr = '0; wdata = '0; wtag = '0;

        // ---------------- reset state ----------------
        set_rd(0, 5, 1'b1);
        set_rd(1, 3, 1'b1);
        #12;
        check("reset_ready", ready, 0);
        check("reset_rdata0", rd_data(0), 0);
        check("reset_rbusy", rbusy, 0);
        check("reset_rtag", rtag, 0);

        // ---------------- zero fill, with writes/claims ignored ----------------
        @(negedge clk);
        we = 1'b1; waddr = 5'd1; wdata = 32'hFFFF_FFFF; wtag = 4'd0;
        iss_valid = 1'b1; iss_rd = 5'd2; iss_tag = 4'd7;
        rst = 1'b1;
        wait_ready();
        we = 1'b0; iss_valid = 1'b0;
        check("fill_cycles", cycles, 31);

        for (int r = 0; r < NREG; r++) begin
            set_rd(0, r, 1'b1);
            set_rd(1, NREG - 1 - r, 1'b1);
            #1;
            check($sformatf("fill_zero_p0_r%0d", r), rd_data(0), 0);
            check($sformatf("fill_zero_p1_r%0d", NREG - 1 - r), rd_data(1), 0);
            check($sformatf("fill_busy_r%0d", r), rbusy, 0);
        end

        // ---------------- bypass, x0, disabled port ----------------
        @(negedge clk);
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        set_rd(0, 5, 1'b1);
        set_rd(1, 6, 1'b1);
        #1;
        check("bypass_same_cycle", rd_data(0), 32'hDEAD_BEEF);
        check("bypass_other_reg", rd_data(1), 0);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("array_after_write", rd_data(0), 32'hDEAD_BEEF);
        set_rd(1, 5, 1'b0);
        #1;
        check("port_disabled", rd_data(1), 0);

        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'h0000_1234;
        set_rd(0, 0, 1'b1);
        #1;
        check("x0_bypass_blocked", rd_data(0), 0);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("x0_read_zero", rd_data(0), 0);
        check("x0_not_busy", rbusy[0], 0);

        // ---------------- scoreboard claim / stale / matching commit ----------------
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd7; iss_tag = 4'd3;
        set_rd(0, 7, 1'b1);
        #1;
        check("claim_not_yet_visible", rbusy[0], 0);
        @(negedge clk);
        iss_valid = 1'b0;
        #1;
        check("claim_busy", rbusy[0], 1);
        check("claim_tag", rd_tag(0), 3);

        we = 1'b1; waddr = 5'd7; wdata = 32'h0000_A5A5; wtag = 4'd2;
        #1;
        check("stale_commit_still_busy", rbusy[0], 1);
        check("stale_commit_bypass", rd_data(0), 32'h0000_A5A5);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("stale_after_busy", rbusy[0], 1);
        check("stale_after_tag", rd_tag(0), 3);
        check("stale_after_data", rd_data(0), 32'h0000_A5A5);

        we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0077; wtag = 4'd3;
        #1;
        check("match_commit_clear_same_cycle", rbusy[0], 0);
        check("match_commit_bypass", rd_data(0), 32'h0000_0077);
        @(negedge clk);
        we = 1'b0;
        #1;
        check("match_after_busy", rbusy[0], 0);
        check("match_after_data", rd_data(0), 32'h0000_0077);

        // ---------------- simultaneous claim and commit ----------------
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd9; iss_tag = 4'd1;
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd9; iss_tag = 4'd5;
        we = 1'b1; waddr = 5'd9; wdata = 32'h0000_9999; wtag = 4'd1;
        @(negedge clk);
        iss_valid = 1'b0; we = 1'b0;
        set_rd(0, 9, 1'b1);
        #1;
        check("claim_wins_busy", rbusy[0], 1);
        check("claim_wins_tag", rd_tag(0), 5);
        check("claim_wins_data", rd_data(0), 32'h0000_9999);

        // ---------------- flush ----------------
        for (int r = 1; r <= 4; r++) begin
            @(negedge clk);
            iss_valid = 1'b1; iss_rd = AW'(r); iss_tag = TAG_W'(r);
        end
        @(negedge clk);
        iss_valid = 1'b0;
        set_rd(0, 4, 1'b1);
        set_rd(1, 2, 1'b1);
        #1;
        check("preflush_busy4", rbusy[0], 1);
        check("preflush_tag4", rd_tag(0), 4);
        check("preflush_tag2", rd_tag(1), 2);

        flush = 1'b1;
        iss_valid = 1'b1; iss_rd = 5'd6; iss_tag = 4'd2;
        we = 1'b1; waddr = 5'd10; wdata = 32'h0000_1010; wtag = 4'd0;
        @(negedge clk);
        flush = 1'b0; iss_valid = 1'b0; we = 1'b0;
        for (int r = 1; r <= 12; r++) begin
            set_rd(0, r, 1'b1);
            #1;
            check($sformatf("flush_busy_r%0d", r), rbusy[0], 0);
        end
        set_rd(1, 10, 1'b1);
        #1;
        check("flush_commit_data", rd_data(1), 32'h0000_1010);

        // ---------------- mid-operation reset ----------------
        @(negedge clk);
        iss_valid = 1'b1; iss_rd = 5'd12; iss_tag = 4'd6;
        @(negedge clk);
        iss_valid = 1'b0;
        set_rd(0, 12, 1'b1);
        set_rd(1, 5, 1'b1);
        #1;
        check("prereset_busy12", rbusy[0], 1);
        check("prereset_data5", rd_data(1), 32'hDEAD_BEEF);

        @(negedge clk);
        rst = 1'b0;
        #2;
        check("midreset_ready", ready, 0);
        check("midreset_rbusy", rbusy, 0);
        check("midreset_rtag", rtag, 0);
        check("midreset_rdata", rdata, 0);
        #1;
        rst = 1'b1;
        wait_ready();
        check("refill_cycles", cycles, 31);
        set_rd(0, 12, 1'b1);
        #1;
        check("refill_busy12", rbusy[0], 0);
        check("refill_tag12", rd_tag(0), 0);
        for (int r = 0; r < NREG; r++) begin
            set_rd(1, r, 1'b1);
            #1;
            check($sformatf("refill_zero_r%0d", r), rd_data(1), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor of the core's integer register file: NRD combinational read ports, one commit write port and a per-register rename scoreboard (busy bit + producer tag) for the out-of-order issue stage.
- Adds a post-reset zero-fill sequencer and a single-cycle flush.
- Sits between decode/issue (reads, busy/tag lookup, destination claim) and the commit stage (architectural write).

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers; power of two, at least 2.
- NRD, 2, number of read ports.
- TAG_W, 4, producer tag width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- ready  out  1  high once zero-fill is complete.
- flush  in  1  clears all busy bits.
- re  in  NRD  per-port read enable.
- raddr  in  NRD*AW  packed read addresses, with AW=$clog2(NREG); port i is at [i*AW +: AW].
- rdata  out  NRD*XLEN  packed read data.
- rbusy  out  NRD  register has an outstanding producer.
- rtag  out  NRD*TAG_W  producer tag of the read register.
- iss_valid  in  1  claim a destination.
- iss_rd  in  AW  destination register.
- iss_tag  in  TAG_W  producer tag.
- we  in  1  commit write enable.
- waddr  in  AW  commit register.
- wdata  in  XLEN  commit data.
- wtag  in  TAG_W  tag of the committing producer.

Behaviour:
- Reset (rst low, asynchronous): state goes to INIT, fill counter to 1, all busy bits to 0, tags to 0, ready to 0. Outputs during reset: rdata=0, rbusy=0, rtag=0. The data array itself has no reset.
- FSM INIT:
  - Writes zero to regs[cnt] each cycle, cnt running 1..NREG-1.
  - Moves to RUN in the cycle after it writes NREG-1.
  - In RUN, ready=1, registered.
  - The fill therefore takes NREG-1 cycles after rst rises.
  - In INIT: we, iss_valid and flush are ignored; reads return rdata=0, rbusy=0, rtag=0.
- FSM RUN: stays in RUN until the next reset. Reset asserted mid-fill or mid-operation restarts INIT from 1.
- Register 0: reads always return 0, never busy, tag 0. Writes and claims to register 0 are dropped.
- Read port i:
  - If re[i]=0 or raddr=0, the port outputs zero.
  - Otherwise it outputs regs[raddr] combinationally.
  - Bypass: if we=1 and waddr==raddr, rdata = wdata in the same cycle.
  - rbusy/rtag show the current registered scoreboard state, then the same-cycle commit clear below.
- Commit, at the clk edge in RUN with we=1 and waddr!=0:
  - regs[waddr] <= wdata unconditionally.
  - busy[waddr] clears only if busy=1 and tag[waddr]==wtag. A stale commit (tag mismatch) updates data and leaves busy set.
  - Read ports see this clear combinationally in the same cycle (rbusy=0).
- Claim, at the clk edge in RUN with iss_valid=1 and iss_rd!=0: busy[iss_rd] <= 1 and tag[iss_rd] <= iss_tag.
- Simultaneous claim and commit to the same register: the claim wins, so busy=1 with the new tag; the data write still happens.
- flush=1 in RUN: all busy bits clear at the edge, and a claim in the same cycle is discarded. A commit in the same cycle still writes data.
- Latencies:
  - Read: 0 cycles.
  - Write: visible through the array on the next cycle, and through the bypass in the same cycle.
  - Scoreboard update: visible on the next cycle.
- Widths: the comparison waddr==raddr is over AW bits. The fill counter is AW bits wide and does not wrap, because it stops at NREG-1.

Decomposition:
- Shared package core_pkg holds XLEN, NREG, AW (derived via $clog2), TAG_W defaults, the enable-level constants and ZERO_WORD.
- One natural sub-module, regfile_rdport, instantiated NRD times in a generate loop. Inputs: re, raddr, the array/busy/tag views and the commit inputs. Outputs: rdata, rbusy, rtag. It owns the x0 and bypass logic.
- The FSM, array and scoreboard stay in regfile_sb.

Test Plan:
- Reset fill, NREG=32: release rst, count cycles → ready rises after 31 cycles. Afterwards, reading every register returns 0 with rbusy=0. Asserting we during INIT leaves the target register at 0.
- Bypass and x0: in one cycle drive we=1, waddr=5, wdata=0xDEADBEEF and raddr0=5 → rdata0=0xDEADBEEF in the same cycle. Write 0x1234 to register 0 → reads of 0 return 0.
- Scoreboard: claim rd=7, tag=3; then commit waddr=7, wtag=2 → data written, rbusy=1, rtag=3. Commit wtag=3 → rbusy=0 in that same cycle.
- Same-cycle claim and commit: iss_rd=9, iss_tag=5, with we=1, waddr=9, wtag=(the old tag 1) → next cycle busy=1, tag=5, regs[9]=wdata.
- Flush: claim registers 1..4, then pulse flush together with iss_valid for rd=6 → next cycle all rbusy=0, including register 6.
- Mid-operation reset: with busy bits set, pulse rst low for a partial cycle → ready=0 immediately, busy bits cleared, fill restarts, and all registers read 0 after ready.
